mem_req_sequencer: RTL and testbench
====================================

Name: mem_req_sequencer

Overview:
- Upstream driver for the 8x8 memory unit (address decoder + 8 wordcells + control FSM).
- Accepts read/write requests over a valid/ready handshake and drives the unit's op/select/adr/in pins with the required phase timing.
- For reads, captures the unit's 8-bit out word and returns it on a valid/ready response channel.
- Replaces hand-sequenced testbench stimulus with a reusable block.

Parameters:
INIT_CYCLES, 3, idle cycles (op=0, select=0) driven after reset so the memory FSM settles into its idle state; range 1..15
WRITE_CYCLES, 2, cycles op=1/select=1 is held for a write; range 1..15
SETTLE_CYCLES, 2, cycles op=0/select=0 (stable state) driven after every write or read; range 1..15
READ_CYCLES, 2, minimum cycles op=0/select=1 is held before sampling read data; range 1..15
TIMEOUT, 8, extra read cycles allowed for mem_valid before aborting with error; range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_write  in  1  1 = write, 0 = read
req_adr  in  3  word address
req_data  in  8  write data (ignored on reads)
resp_valid  out  1  read data available
resp_ready  in  1  consumer accepts response
resp_data  out  8  captured read word
resp_err  out  1  read timed out (resp_data = 8'h00)
busy  out  1  high in every state except READY
mem_op  out  1  to memory unit op
mem_select  out  1  to memory unit select
mem_adr  out  3  to memory unit adr
mem_in  out  8  to memory unit in
mem_out  in  8  from memory unit out
mem_valid  in  1  from memory unit valid
mem_rw  in  1  from memory unit rw (1 = read phase)

Behaviour:
- Reset (async, rst_n=0): state INIT, counter 0; mem_op=0, mem_select=0, mem_adr=0, mem_in=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, busy=1.
- All outputs are registered. A 4-bit down-counter times every phase.
- INIT: drive op=0/select=0 for INIT_CYCLES, then go to READY.
- READY: req_ready=1, busy=0, op=0/select=0. On req_valid&&req_ready:
  - Latch req_adr into mem_adr and req_data into mem_in (mem_in is left unchanged on reads).
  - Go to WRITE if req_write=1, else READ.
  - req_ready drops the cycle after acceptance.
- WRITE: op=1/select=1 for exactly WRITE_CYCLES, then SETTLE. mem_valid/mem_rw are ignored.
- SETTLE: op=0/select=0 for SETTLE_CYCLES.
  - After a write, go to READY.
  - After a read, go to RESP.
- READ: op=0/select=1.
  - After READ_CYCLES, sample mem_out on the first cycle with mem_valid=1 && mem_rw=1: resp_data=mem_out, resp_err=0, go to SETTLE.
  - If no such cycle occurs within TIMEOUT further cycles: resp_data=0, resp_err=1, go to SETTLE.
- RESP: resp_valid=1; resp_data/resp_err are held stable until resp_ready=1. Then resp_valid=0 next cycle and go to READY.
- Minimum request-to-request spacing:
  - Write: 1 (accept) + WRITE_CYCLES + SETTLE_CYCLES.
  - Read: 1 + READ_CYCLES + wait + SETTLE_CYCLES + RESP.
- Exactly one outstanding request; no back-to-back acceptance. req_valid in non-READY states is ignored (not lost; the producer holds it).
- mem_adr and mem_in are held constant from acceptance until return to READY.
- Reset mid-operation (any state) aborts immediately to INIT values. Any pending response is discarded.
- resp_ready asserted while resp_valid=0 has no effect.

Test Plan:
- Reset release: after INIT_CYCLES=3 cycles of op/select=00, req_ready=1 on cycle 4.
- Write adr=3'b000, data=8'h55 -> mem_op/select=11 for 2 cycles with mem_adr=000, mem_in=8'h55, then 00 for 2 cycles, then req_ready=1.
- Read adr=000 with model returning 8'h55, mem_valid=1, mem_rw=1 -> select=1/op=0 for 2 cycles, resp_valid=1, resp_data=8'h55, resp_err=0.
- Read with mem_valid stuck 0 -> after READ_CYCLES+TIMEOUT=10 cycles, resp_valid=1, resp_err=1, resp_data=8'h00.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0; release -> READY next cycle.
- rst_n pulsed low during WRITE -> mem_op=0, mem_select=0, resp_valid=0 immediately; INIT sequence restarts.

Source files
------------

// File: rtl/mem_req_sequencer_if.sv
// Request/response channel plus memory-unit pin bundle for mem_req_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface mem_req_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_adr;
    logic [7:0] req_data;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       busy;
    logic       mem_op;
    logic       mem_select;
    logic [2:0] mem_adr;
    logic [7:0] mem_in;
    logic [7:0] mem_out;
    logic       mem_valid;
    logic       mem_rw;

    modport slave (
        input  req_valid, req_write, req_adr, req_data, resp_ready,
               mem_out, mem_valid, mem_rw,
        output req_ready, resp_valid, resp_data, resp_err, busy,
               mem_op, mem_select, mem_adr, mem_in
    );

    modport master (
        output req_valid, req_write, req_adr, req_data, resp_ready,
               mem_out, mem_valid, mem_rw,
        input  req_ready, resp_valid, resp_data, resp_err, busy,
               mem_op, mem_select, mem_adr, mem_in
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// Sequences single read/write requests onto the 8x8 memory unit pins with
// fixed phase timing and returns read words on a valid/ready response channel.
module mem_req_sequencer #(
    parameter int unsigned INIT_CYCLES   = 3,
    parameter int unsigned WRITE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned READ_CYCLES   = 2,
    parameter int unsigned TIMEOUT       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_req_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_READY,
        S_WRITE,
        S_SETTLE,
        S_READ,
        S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       readOp_q, readOp_d;
    logic       waitPhase_q, waitPhase_d;
    logic       memOp_q, memOp_d;
    logic       memSelect_q, memSelect_d;
    logic [2:0] memAdr_q, memAdr_d;
    logic [7:0] memIn_q, memIn_d;
    logic       reqReady_q, reqReady_d;
    logic       respValid_q, respValid_d;
    logic [7:0] respData_q, respData_d;
    logic       respErr_q, respErr_d;
    logic       busy_q, busy_d;
    logic       memHit;

    assign memHit = bus.mem_valid && bus.mem_rw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= 4'd0;
            readOp_q    <= 1'b0;
            waitPhase_q <= 1'b0;
            memOp_q     <= 1'b0;
            memSelect_q <= 1'b0;
            memAdr_q    <= 3'd0;
            memIn_q     <= 8'd0;
            reqReady_q  <= 1'b0;
            respValid_q <= 1'b0;
            respData_q  <= 8'd0;
            respErr_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readOp_q    <= readOp_d;
            waitPhase_q <= waitPhase_d;
            memOp_q     <= memOp_d;
            memSelect_q <= memSelect_d;
            memAdr_q    <= memAdr_d;
            memIn_q     <= memIn_d;
            reqReady_q  <= reqReady_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
            respErr_q   <= respErr_d;
            busy_q      <= busy_d;
        end
    end

    // Outputs are registered, so each transition also sets the next state's pin values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        readOp_d    = readOp_q;
        waitPhase_d = waitPhase_q;
        memOp_d     = memOp_q;
        memSelect_d = memSelect_q;
        memAdr_d    = memAdr_q;
        memIn_d     = memIn_q;
        reqReady_d  = reqReady_q;
        respValid_d = respValid_q;
        respData_d  = respData_q;
        respErr_d   = respErr_q;
        busy_d      = busy_q;

        case (state_q)
            // INIT counts up from the reset value; every later phase loads and counts down.
            S_INIT: begin
                if (cnt_q == 4'(INIT_CYCLES - 1)) begin
                    state_d    = S_READY;
                    cnt_d      = 4'd0;
                    reqReady_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_READY: begin
                if (bus.req_valid && reqReady_q) begin
                    reqReady_d  = 1'b0;
                    busy_d      = 1'b1;
                    memAdr_d    = bus.req_adr;
                    memSelect_d = 1'b1;
                    if (bus.req_write) begin
                        state_d  = S_WRITE;
                        memIn_d  = bus.req_data;
                        memOp_d  = 1'b1;
                        readOp_d = 1'b0;
                        cnt_d    = 4'(WRITE_CYCLES - 1);
                    end else begin
                        state_d     = S_READ;
                        memOp_d     = 1'b0;
                        readOp_d    = 1'b1;
                        waitPhase_d = 1'b0;
                        cnt_d       = 4'(READ_CYCLES - 1);
                    end
                end
            end

            S_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d     = S_SETTLE;
                    memOp_d     = 1'b0;
                    memSelect_d = 1'b0;
                    cnt_d       = 4'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            // The last minimum-hold cycle is already a sampling opportunity.
            S_READ: begin
                if ((cnt_q == 4'd0 || waitPhase_q) && memHit) begin
                    state_d     = S_SETTLE;
                    memSelect_d = 1'b0;
                    respData_d  = bus.mem_out;
                    respErr_d   = 1'b0;
                    cnt_d       = 4'(SETTLE_CYCLES - 1);
                end else if (cnt_q == 4'd0 && !waitPhase_q) begin
                    waitPhase_d = 1'b1;
                    cnt_d       = 4'(TIMEOUT - 1);
                end else if (cnt_q == 4'd0) begin
                    state_d     = S_SETTLE;
                    memSelect_d = 1'b0;
                    respData_d  = 8'h00;
                    respErr_d   = 1'b1;
                    cnt_d       = 4'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    if (readOp_q) begin
                        state_d     = S_RESP;
                        respValid_d = 1'b1;
                    end else begin
                        state_d    = S_READY;
                        reqReady_d = 1'b1;
                        busy_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d     = S_READY;
                    respValid_d = 1'b0;
                    reqReady_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d = S_INIT;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign bus.req_ready  = reqReady_q;
    assign bus.resp_valid = respValid_q;
    assign bus.resp_data  = respData_q;
    assign bus.resp_err   = respErr_q;
    assign bus.busy       = busy_q;
    assign bus.mem_op     = memOp_q;
    assign bus.mem_select = memSelect_q;
    assign bus.mem_adr    = memAdr_q;
    assign bus.mem_in     = memIn_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer: reset, write, read, timeout,
// response backpressure and reset during a write.
module tb_mem_req_sequencer;

    logic clk;
    logic rst_n;
    int   assertCount = 0;
    int   failCount   = 0;

    mem_req_sequencer_if bus ();

    mem_req_sequencer #(
        .INIT_CYCLES  (3),
        .WRITE_CYCLES (2),
        .SETTLE_CYCLES(2),
        .READ_CYCLES  (2),
        .TIMEOUT      (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [2:0] adr, input logic [7:0] data);
        bus.req_valid = valid;
        bus.req_write = write;
        bus.req_adr   = adr;
        bus.req_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
        bus.resp_ready = 1'b0;
        bus.mem_out    = 8'h00;
        bus.mem_valid  = 1'b0;
        bus.mem_rw     = 1'b0;

        #8;
        $display("[TB] reset values");
        checkOutput("rst_op",         bus.mem_op,     8'd0);
        checkOutput("rst_select",     bus.mem_select, 8'd0);
        checkOutput("rst_adr",        bus.mem_adr,    8'd0);
        checkOutput("rst_in",         bus.mem_in,     8'h00);
        checkOutput("rst_req_ready",  bus.req_ready,  8'd0);
        checkOutput("rst_resp_valid", bus.resp_valid, 8'd0);
        checkOutput("rst_resp_data",  bus.resp_data,  8'h00);
        checkOutput("rst_resp_err",   bus.resp_err,   8'd0);
        checkOutput("rst_busy",       bus.busy,       8'd1);

        #14 rst_n = 1'b1;
        tick();
        checkOutput("init1_req_ready", bus.req_ready, 8'd0);
        tick();
        checkOutput("init2_req_ready", bus.req_ready, 8'd0);
        checkOutput("init2_select",    bus.mem_select, 8'd0);
        tick();
        checkOutput("init3_req_ready", bus.req_ready, 8'd1);
        checkOutput("init3_busy",      bus.busy,      8'd0);

        $display("[TB] write adr=0 data=55");
        applyStimulus(1'b1, 1'b1, 3'd0, 8'h55);
        bus.mem_valid = 1'b1;
        bus.mem_rw    = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
        checkOutput("wr1_op",        bus.mem_op,     8'd1);
        checkOutput("wr1_select",    bus.mem_select, 8'd1);
        checkOutput("wr1_adr",       bus.mem_adr,    8'd0);
        checkOutput("wr1_in",        bus.mem_in,     8'h55);
        checkOutput("wr1_req_ready", bus.req_ready,  8'd0);
        checkOutput("wr1_busy",      bus.busy,       8'd1);
        tick();
        checkOutput("wr2_op",     bus.mem_op,     8'd1);
        checkOutput("wr2_select", bus.mem_select, 8'd1);
        tick();
        checkOutput("wr_settle1_op",     bus.mem_op,     8'd0);
        checkOutput("wr_settle1_select", bus.mem_select, 8'd0);
        checkOutput("wr_settle1_ready",  bus.req_ready,  8'd0);
        tick();
        checkOutput("wr_settle2_ready", bus.req_ready, 8'd0);
        tick();
        checkOutput("wr_done_ready", bus.req_ready, 8'd1);
        checkOutput("wr_done_in",    bus.mem_in,    8'h55);

        $display("[TB] read adr=0 with backpressure");
        applyStimulus(1'b1, 1'b0, 3'd0, 8'hFF);
        bus.mem_out = 8'hAA;
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
        checkOutput("rd1_op",        bus.mem_op,     8'd0);
        checkOutput("rd1_select",    bus.mem_select, 8'd1);
        checkOutput("rd1_in_kept",   bus.mem_in,     8'h55);
        checkOutput("rd1_req_ready", bus.req_ready,  8'd0);
        tick();
        bus.mem_out = 8'h55;
        checkOutput("rd2_select", bus.mem_select, 8'd1);
        tick();
        checkOutput("rd_settle_select", bus.mem_select, 8'd0);
        checkOutput("rd_settle_valid",  bus.resp_valid, 8'd0);
        tick();
        tick();
        checkOutput("rd_resp_valid", bus.resp_valid, 8'd1);
        checkOutput("rd_resp_data",  bus.resp_data,  8'h55);
        checkOutput("rd_resp_err",   bus.resp_err,   8'd0);
        applyStimulus(1'b1, 1'b0, 3'd6, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_resp_valid", bus.resp_valid, 8'd1);
            checkOutput("bp_resp_data",  bus.resp_data,  8'h55);
            checkOutput("bp_req_ready",  bus.req_ready,  8'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        checkOutput("bp_release_valid", bus.resp_valid, 8'd0);
        checkOutput("bp_release_ready", bus.req_ready,  8'd1);
        checkOutput("bp_release_busy",  bus.busy,       8'd0);

        $display("[TB] pending read adr=6 times out");
        bus.mem_valid = 1'b1;
        bus.mem_rw    = 1'b0;
        bus.mem_out   = 8'h77;
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
        checkOutput("to1_select",    bus.mem_select, 8'd1);
        checkOutput("to1_adr",       bus.mem_adr,    8'd6);
        checkOutput("to1_req_ready", bus.req_ready,  8'd0);
        for (int i = 2; i <= 10; i++) begin
            tick();
            checkOutput("to_select_held", bus.mem_select, 8'd1);
        end
        tick();
        bus.resp_ready = 1'b1;
        checkOutput("to_settle_select", bus.mem_select, 8'd0);
        checkOutput("to_settle_err",    bus.resp_err,   8'd1);
        checkOutput("to_settle_data",   bus.resp_data,  8'h00);
        checkOutput("to_settle_valid",  bus.resp_valid, 8'd0);
        tick();
        tick();
        checkOutput("to_resp_valid", bus.resp_valid, 8'd1);
        checkOutput("to_resp_err",   bus.resp_err,   8'd1);
        checkOutput("to_resp_data",  bus.resp_data,  8'h00);
        tick();
        bus.resp_ready = 1'b0;
        checkOutput("to_done_valid", bus.resp_valid, 8'd0);
        checkOutput("to_done_ready", bus.req_ready,  8'd1);

        $display("[TB] reset during write");
        applyStimulus(1'b1, 1'b1, 3'd5, 8'hA3);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
        checkOutput("wr5_op",  bus.mem_op,  8'd1);
        checkOutput("wr5_adr", bus.mem_adr, 8'd5);
        checkOutput("wr5_in",  bus.mem_in,  8'hA3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_op",         bus.mem_op,     8'd0);
        checkOutput("midrst_select",     bus.mem_select, 8'd0);
        checkOutput("midrst_resp_valid", bus.resp_valid, 8'd0);
        checkOutput("midrst_busy",       bus.busy,       8'd1);
        checkOutput("midrst_in",         bus.mem_in,     8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("reinit2_req_ready", bus.req_ready, 8'd0);
        tick();
        checkOutput("reinit3_req_ready", bus.req_ready, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
